// File: rtl/scanner_thresh_ctrl_pkg.sv
// Shared definitions for the RGB-to-binary scanner threshold controller.
// Provides the FSM state encoding, host write address constants, the
// default threshold value and a write-address decode helper.
package scanner_thresh_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EVAL  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_RED   = 2'd0;
  localparam logic [1:0] ADDR_GREEN = 2'd1;
  localparam logic [1:0] ADDR_BLUE  = 2'd2;
  localparam logic [1:0] ADDR_ALL   = 2'd3;

  localparam logic [7:0] DEF_THRESH_C = 8'd128;

  // True when a host write to 'addr' targets channel 'ch' (0=R, 1=G, 2=B).
  function automatic logic addr_hit(input logic [1:0] addr, input logic [1:0] ch);
    return (addr == ch) || (addr == ADDR_ALL);
  endfunction

endpackage

// File: rtl/scanner_thresh_ctrl_sat_step.sv
// scanner_sat_step: 8-bit saturating step adder used by threshold auto-adjust.
// Ports:
//   in_val  - current 8-bit threshold
//   inc     - add STEP, saturating at 255 (has priority over dec)
//   dec     - subtract STEP, saturating at 0
//   out_val - stepped value (in_val when neither inc nor dec)
module scanner_sat_step #(
  parameter int unsigned STEP = 1
) (
  input  logic [7:0] in_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] out_val
);

  logic [8:0] sum;
  logic [8:0] diff;

  always_comb begin
    sum     = {1'b0, in_val} + 9'(STEP);
    diff    = {1'b0, in_val} - 9'(STEP);
    out_val = in_val;
    if (inc) begin
      out_val = sum[8] ? 8'hFF : sum[7:0];
    end else if (dec) begin
      // Borrow out of bit 8 means the result went below zero.
      out_val = diff[8] ? 8'h00 : diff[7:0];
    end
  end

endmodule

// File: rtl/scanner_thresh_ctrl.sv
// scanner_thresh_ctrl: threshold controller for the RGB-to-binary scanner.
// Host-written R/G/B thresholds live in shadow registers and are committed to
// the active (output) registers only on the frame-start strobe, so the scanner
// never sees a threshold change mid-frame. Binary-1 pixels are counted per
// frame; the count of each completed frame is published with a one-cycle pulse.
// Optional feature macro: SCANNER_AUTO_THRESH_EN enables auto-adjust of the
// shadow thresholds toward the [iTargetLo, iTargetHi] foreground band.
// Ports:
//   iClk, iRst (async active-low)
//   iPixelSync   - frame-start strobe      iPixelActive/iDataBin - pixel stream
//   iWrEn/iWrAddr/iWrData - host shadow write (addr 3 = all channels)
//   iAutoEn, iTargetLo, iTargetHi - auto-adjust controls (macro builds only)
//   oThreshRed/Green/Blue - active thresholds
//   oFrameCount/oFrameDone - last frame foreground count and update pulse
//   oState - FSM state (0 idle, 1 accumulate, 2 evaluate)
module scanner_thresh_ctrl
  import scanner_thresh_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 22,
  parameter int unsigned STEP       = 1,
  parameter logic [7:0]  DEF_THRESH = DEF_THRESH_C
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iPixelSync,
  input  logic             iPixelActive,
  input  logic             iDataBin,
  input  logic             iWrEn,
  input  logic [1:0]       iWrAddr,
  input  logic [7:0]       iWrData,
  input  logic             iAutoEn,
  input  logic [CNT_W-1:0] iTargetLo,
  input  logic [CNT_W-1:0] iTargetHi,
  output logic [7:0]       oThreshRed,
  output logic [7:0]       oThreshGreen,
  output logic [7:0]       oThreshBlue,
  output logic [CNT_W-1:0] oFrameCount,
  output logic             oFrameDone,
  output logic [1:0]       oState
);

  state_e                state_q, state_d;
  logic [2:0][7:0]       shadow_q, shadow_d;
  logic [2:0][7:0]       active_q, active_d;
  logic [2:0][7:0]       adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      fcnt_q, fcnt_d;
  logic                  done_q, done_d;
  logic                  fg;

  assign fg = iPixelActive & iDataBin;

`ifdef SCANNER_AUTO_THRESH_EN
  logic adj_inc;
  logic adj_dec;

  always_comb begin
    adj_inc = 1'b0;
    adj_dec = 1'b0;
    if (state_q == ST_EVAL && iAutoEn) begin
      if (fcnt_q > iTargetHi) begin
        adj_inc = 1'b1;
      end else if (fcnt_q < iTargetLo) begin
        adj_dec = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_step
    scanner_sat_step #(.STEP(STEP)) u_step (
      .in_val (shadow_q[g]),
      .inc    (adj_inc),
      .dec    (adj_dec),
      .out_val(adj[g])
    );
  end
`else
  localparam int unsigned UNUSED_STEP = STEP;
  logic unused_auto;

  assign adj         = shadow_q;
  assign unused_auto = ^{iAutoEn, iTargetLo, iTargetHi};
`endif

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    fcnt_d   = fcnt_q;
    done_d   = 1'b0;

    // Host write overrides the auto-adjusted value per addressed channel.
    shadow_d = adj;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      if (iWrEn && addr_hit(iWrAddr, 2'(ch))) begin
        shadow_d[ch] = iWrData;
      end
    end

    // The sync-cycle pixel already belongs to the new frame.
    if (iPixelSync) begin
      cnt_d = CNT_W'(fg);
    end else if (fg && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (iPixelSync) begin
      active_d = shadow_q;
      case (state_q)
        ST_IDLE: state_d = ST_ACCUM;
        default: begin
          fcnt_d  = cnt_q;
          done_d  = 1'b1;
          state_d = ST_EVAL;
        end
      endcase
    end else if (state_q == ST_EVAL) begin
      state_d = ST_ACCUM;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q  <= ST_IDLE;
      shadow_q <= {3{DEF_THRESH}};
      active_q <= {3{DEF_THRESH}};
      cnt_q    <= '0;
      fcnt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      done_q   <= done_d;
    end
  end

  assign oThreshRed   = active_q[0];
  assign oThreshGreen = active_q[1];
  assign oThreshBlue  = active_q[2];
  assign oFrameCount  = fcnt_q;
  assign oFrameDone   = done_q;
  assign oState       = state_q;

endmodule

// File: tb/tb_scanner_thresh_ctrl.sv
module tb_scanner_thresh_ctrl;

  localparam int MAX22 = 4194303;
  localparam int MAX4  = 15;
  localparam int STEP_TB = 1;

  logic        clk;
  logic        rst;
  logic        sync;
  logic        pa;
  logic        db;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        auto_en;
  logic [21:0] t_lo;
  logic [21:0] t_hi;

  logic [7:0]  o_r, o_g, o_b;
  logic [21:0] o_fc;
  logic        o_done;
  logic [1:0]  o_st;

  logic [7:0]  unused_r4, unused_g4, unused_b4;
  logic [3:0]  fc4;
  logic        unused_done4;
  logic [1:0]  unused_st4;

  int n_pass;
  int n_total;

  // Reference model state
  int m_sh[3];
  int m_act[3];
  int nsh[3];
  int m_cnt, m_cnt4, m_fc, m_fc4, fg;
  bit m_started, m_eval, m_done;

  scanner_thresh_ctrl dut (
    .iClk(clk), .iRst(rst), .iPixelSync(sync), .iPixelActive(pa), .iDataBin(db),
    .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data), .iAutoEn(auto_en),
    .iTargetLo(t_lo), .iTargetHi(t_hi),
    .oThreshRed(o_r), .oThreshGreen(o_g), .oThreshBlue(o_b),
    .oFrameCount(o_fc), .oFrameDone(o_done), .oState(o_st)
  );

  scanner_thresh_ctrl #(.CNT_W(4)) dut4 (
    .iClk(clk), .iRst(rst), .iPixelSync(sync), .iPixelActive(pa), .iDataBin(db),
    .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data), .iAutoEn(auto_en),
    .iTargetLo(t_lo[3:0]), .iTargetHi(t_hi[3:0]),
    .oThreshRed(unused_r4), .oThreshGreen(unused_g4), .oThreshBlue(unused_b4),
    .oFrameCount(fc4), .oFrameDone(unused_done4), .oState(unused_st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: thresholds as integers, frame bookkeeping as flags.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        m_sh[c]  = 128;
        m_act[c] = 128;
      end
      m_cnt = 0; m_cnt4 = 0; m_fc = 0; m_fc4 = 0;
      m_started = 1'b0; m_eval = 1'b0; m_done = 1'b0;
    end else begin
      fg = (pa && db) ? 1 : 0;
      for (int c = 0; c < 3; c++) nsh[c] = m_sh[c];
`ifdef SCANNER_AUTO_THRESH_EN
      if (m_eval && auto_en) begin
        for (int c = 0; c < 3; c++) begin
          if (m_fc > int'(t_hi))
            nsh[c] = (m_sh[c] + STEP_TB > 255) ? 255 : m_sh[c] + STEP_TB;
          else if (m_fc < int'(t_lo))
            nsh[c] = (m_sh[c] - STEP_TB < 0) ? 0 : m_sh[c] - STEP_TB;
        end
      end
`endif
      for (int c = 0; c < 3; c++)
        if (wr_en && (wr_addr == 2'd3 || int'(wr_addr) == c)) nsh[c] = int'(wr_data);
      if (sync) begin
        for (int c = 0; c < 3; c++) m_act[c] = m_sh[c];
        if (m_started) begin
          m_fc = m_cnt; m_fc4 = m_cnt4; m_done = 1'b1; m_eval = 1'b1;
        end else begin
          m_started = 1'b1; m_done = 1'b0; m_eval = 1'b0;
        end
        m_cnt = fg; m_cnt4 = fg;
      end else begin
        m_done = 1'b0; m_eval = 1'b0;
        m_cnt  = (m_cnt + fg > MAX22) ? MAX22 : m_cnt + fg;
        m_cnt4 = (m_cnt4 + fg > MAX4) ? MAX4 : m_cnt4 + fg;
      end
      for (int c = 0; c < 3; c++) m_sh[c] = nsh[c];
    end
  end

  function automatic int exp_state();
    return !m_started ? 0 : (m_eval ? 2 : 1);
  endfunction

  task automatic step(input bit s, input bit a, input bit b);
    sync = s; pa = a; db = b;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_reset();
    sync = 1'b0; pa = 1'b0; db = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    auto_en = 1'b0; t_lo = '0; t_hi = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Active pixels in shuffled order with idle gaps; does not issue sync.
  task automatic run_frame(input int n_fg, input int n_bg);
    bit pix[$];
    int j;
    bit t;
    for (int i = 0; i < n_fg; i++) pix.push_back(1'b1);
    for (int i = 0; i < n_bg; i++) pix.push_back(1'b0);
    for (int i = pix.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = pix[i]; pix[i] = pix[j]; pix[j] = t;
    end
    foreach (pix[i]) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(1'b0, 1'b1, pix[i]);
    end
  endtask

  task automatic test_reset();
    do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    n_total++; if (o_r !== 8'd128) $display("FAIL reset_red got %0d exp 128", o_r); else n_pass++;
    n_total++; if (o_g !== 8'd128) $display("FAIL reset_green got %0d exp 128", o_g); else n_pass++;
    n_total++; if (o_b !== 8'd128) $display("FAIL reset_blue got %0d exp 128", o_b); else n_pass++;
    n_total++; if (o_st !== 2'd0) $display("FAIL reset_state got %0d exp 0", o_st); else n_pass++;
    n_total++; if (o_fc !== 22'd0) $display("FAIL reset_count got %0d exp 0", o_fc); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL reset_done got %0d exp 0", o_done); else n_pass++;
  endtask

  task automatic test_commit();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    n_total++; if (o_st !== 2'd1) $display("FAIL first_sync_state got %0d exp 1", o_st); else n_pass++;
    n_total++; if (o_done !== 1'b0) $display("FAIL first_sync_done got %0d exp 0", o_done); else n_pass++;
    host_write(2'd0, 8'h40);
    for (int i = 0; i < 99; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_total++; if (o_r !== 8'd128) $display("FAIL precommit_red cyc %0d got %0h exp 80", i, o_r); else n_pass++;
    end
    step(1'b1, 1'b0, 1'b0);
    n_total++; if (o_r !== 8'h40) $display("FAIL commit_red got %0h exp 40", o_r); else n_pass++;
    n_total++; if (o_g !== 8'd128) $display("FAIL commit_green got %0h exp 80", o_g); else n_pass++;
    // Write coincident with sync (FSM is in EVAL here) must wait one frame.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h22;
    step(1'b1, 1'b0, 1'b0);
    n_total++; if (o_r !== 8'h40) $display("FAIL sync_write_red got %0h exp 40", o_r); else n_pass++;
    n_total++; if (o_st !== 2'd2) $display("FAIL sync_in_eval_state got %0d exp 2", o_st); else n_pass++;
    run_frame(3, 4);
    step(1'b1, 1'b0, 1'b0);
    n_total++; if (o_r !== 8'h22) $display("FAIL next_sync_red got %0h exp 22", o_r); else n_pass++;
  endtask

  task automatic test_frame_count();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    run_frame(30, 20);
    step(1'b1, 1'b0, 1'b0);
    n_total++; if (o_done !== 1'b1) $display("FAIL done_pulse got %0d exp 1", o_done); else n_pass++;
    n_total++; if (o_fc !== 22'd30) $display("FAIL frame_count got %0d exp 30", o_fc); else n_pass++;
    n_total++; if (fc4 !== 4'd15) $display("FAIL frame_count_w4 got %0d exp 15", fc4); else n_pass++;
    n_total++; if (o_st !== 2'd2) $display("FAIL eval_state got %0d exp 2", o_st); else n_pass++;
    step(1'b0, 1'b1, 1'b1);
    n_total++; if (o_done !== 1'b0) $display("FAIL done_single got %0d exp 0", o_done); else n_pass++;
    n_total++; if (o_st !== 2'd1) $display("FAIL back_to_accum got %0d exp 1", o_st); else n_pass++;
    n_total++; if (o_fc !== 22'd30) $display("FAIL count_hold got %0d exp 30", o_fc); else n_pass++;
    // The in-frame pixel above plus 19 more gives 20 foreground pixels.
    run_frame(19, 7);
    step(1'b1, 1'b0, 1'b0);
    n_total++; if (o_fc !== 22'd20) $display("FAIL frame_count20 got %0d exp 20", o_fc); else n_pass++;
    n_total++; if (fc4 !== 4'd15) $display("FAIL saturate_w4 got %0d exp 15", fc4); else n_pass++;
  endtask

  task automatic test_auto_adjust();
    int er[3];
    do_reset();
    host_write(2'd0, 8'd255);
    host_write(2'd1, 8'd100);
    host_write(2'd2, 8'd0);
    auto_en = 1'b1; t_lo = 22'd10; t_hi = 22'd20;
    step(1'b1, 1'b0, 1'b0);
    run_frame(30, 10);
    step(1'b1, 1'b0, 1'b0);
    n_total++; if ({o_r, o_g, o_b} !== {8'd255, 8'd100, 8'd0}) $display("FAIL auto_base got %0d/%0d/%0d exp 255/100/0", o_r, o_g, o_b); else n_pass++;
    run_frame(5, 10);
    step(1'b1, 1'b0, 1'b0);
`ifdef SCANNER_AUTO_THRESH_EN
    er = '{255, 101, 1};
`else
    er = '{255, 100, 0};
`endif
    n_total++; if ({o_r, o_g, o_b} !== {8'(er[0]), 8'(er[1]), 8'(er[2])}) $display("FAIL auto_high got %0d/%0d/%0d exp %0d/%0d/%0d", o_r, o_g, o_b, er[0], er[1], er[2]); else n_pass++;
    run_frame(15, 3);
    step(1'b1, 1'b0, 1'b0);
`ifdef SCANNER_AUTO_THRESH_EN
    er = '{254, 100, 0};
`endif
    n_total++; if ({o_r, o_g, o_b} !== {8'(er[0]), 8'(er[1]), 8'(er[2])}) $display("FAIL auto_low got %0d/%0d/%0d exp %0d/%0d/%0d", o_r, o_g, o_b, er[0], er[1], er[2]); else n_pass++;
    run_frame(2, 3);
    step(1'b1, 1'b0, 1'b0);
    n_total++; if ({o_r, o_g, o_b} !== {8'(er[0]), 8'(er[1]), 8'(er[2])}) $display("FAIL auto_inband got %0d/%0d/%0d exp %0d/%0d/%0d", o_r, o_g, o_b, er[0], er[1], er[2]); else n_pass++;
    auto_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    host_write(2'd3, 8'h40);
    step(1'b1, 1'b0, 1'b0);
    run_frame(4, 4);
    n_total++; if (o_r !== 8'h40) $display("FAIL mid_pre_red got %0h exp 40", o_r); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if ({o_r, o_g, o_b} !== {3{8'd128}}) $display("FAIL mid_rst_thresh got %0h/%0h/%0h exp 80/80/80", o_r, o_g, o_b); else n_pass++;
    n_total++; if (o_st !== 2'd0) $display("FAIL mid_rst_state got %0d exp 0", o_st); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    n_total++; if (o_done !== 1'b0) $display("FAIL mid_rst_nodone got %0d exp 0", o_done); else n_pass++;
    n_total++; if (o_r !== 8'd128) $display("FAIL mid_rst_commit got %0h exp 80", o_r); else n_pass++;
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int f = 0; f < 14; f++) begin
      auto_en = 1'($urandom_range(0, 1));
      t_lo = 22'($urandom_range(0, 25));
      t_hi = 22'($urandom_range(0, 30));
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(10, 45));
      for (int i = 0; i <= len; i++) begin
        if ($urandom_range(0, 6) == 0) begin
          wr_en = 1'b1; wr_addr = 2'($urandom_range(0, 3)); wr_data = 8'($urandom);
        end
        step(i == len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        n_total++; if (o_r !== 8'(m_act[0])) $display("FAIL rnd_red got %0d exp %0d", o_r, m_act[0]); else n_pass++;
        n_total++; if (o_g !== 8'(m_act[1])) $display("FAIL rnd_green got %0d exp %0d", o_g, m_act[1]); else n_pass++;
        n_total++; if (o_b !== 8'(m_act[2])) $display("FAIL rnd_blue got %0d exp %0d", o_b, m_act[2]); else n_pass++;
        n_total++; if (o_fc !== 22'(m_fc)) $display("FAIL rnd_count got %0d exp %0d", o_fc, m_fc); else n_pass++;
        n_total++; if (fc4 !== 4'(m_fc4)) $display("FAIL rnd_count4 got %0d exp %0d", fc4, m_fc4); else n_pass++;
        n_total++; if (o_done !== m_done) $display("FAIL rnd_done got %0d exp %0d", o_done, m_done); else n_pass++;
        n_total++; if (o_st !== 2'(exp_state())) $display("FAIL rnd_state got %0d exp %0d", o_st, exp_state()); else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    test_reset();
    test_commit();
    test_frame_count();
    test_auto_adjust();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
